// File: rtl/display_rx.sv
// Receive side of the LED-driver serial link: synchronises latch/blank/csel/sclk/sin,
// shifts bits into a holding register and commits it to one of eight row registers on latch.
module display_rx #(
    parameter int DATA_W      = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  latch_i,
    input  logic                  blank_i,
    input  logic [2:0]            csel_i,
    input  logic                  sclk_i,
    input  logic                  sin_i,
    output logic [8*DATA_W-1:0]   row_data_o,
    output logic [7:0]            row_valid_o,
    output logic                  update_o,
    output logic [2:0]            update_row_o,
    output logic                  blank_o,
    output logic                  len_err_o,
    output logic [15:0]           err_cnt_o
);

    localparam logic [6:0] CNT_FULL = 7'(DATA_W);
    localparam logic [6:0] CNT_MAX  = 7'(DATA_W + 1);

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    function automatic logic [6:0] sat_inc_cnt(input logic [6:0] v);
        return (v == CNT_MAX) ? v : v + 7'd1;
    endfunction

    logic [SYNC_STAGES-1:0]      sclk_sync, latch_sync, blank_sync, sin_sync;
    logic [SYNC_STAGES-1:0][2:0] csel_sync;
    logic                        sclk_prev, latch_prev;
    logic                        sclk_rise_p0, latch_rise_p0;
    logic                        sclk_s, latch_s, sin_s;
    logic [2:0]                  csel_s;

    logic [DATA_W-1:0]           shreg, shreg_nx;
    logic [6:0]                  bit_cnt, cnt_nx;
    logic [7:0][DATA_W-1:0]      rows;
    logic [7:0]                  row_valid;
    logic                        update, len_err;
    logic [2:0]                  update_row;
    logic [15:0]                 err_cnt;

    assign sclk_s  = sclk_sync[SYNC_STAGES-1];
    assign latch_s = latch_sync[SYNC_STAGES-1];
    assign sin_s   = sin_sync[SYNC_STAGES-1];
    assign csel_s  = csel_sync[SYNC_STAGES-1];

    // Stage p0: synchronisers and registered edge detects. sclk/latch idle high at reset
    // so a level already high on release is not mistaken for an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sclk_sync     <= '1;
            latch_sync    <= '1;
            sclk_prev     <= 1'b1;
            latch_prev    <= 1'b1;
            blank_sync    <= '0;
            sin_sync      <= '0;
            csel_sync     <= '0;
            sclk_rise_p0  <= 1'b0;
            latch_rise_p0 <= 1'b0;
        end else begin
            sclk_sync     <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            latch_sync    <= {latch_sync[SYNC_STAGES-2:0], latch_i};
            blank_sync    <= {blank_sync[SYNC_STAGES-2:0], blank_i};
            sin_sync      <= {sin_sync[SYNC_STAGES-2:0], sin_i};
            csel_sync     <= {csel_sync[SYNC_STAGES-2:0], csel_i};
            sclk_prev     <= sclk_s;
            latch_prev    <= latch_s;
            sclk_rise_p0  <= sclk_s & ~sclk_prev;
            latch_rise_p0 <= latch_s & ~latch_prev;
        end
    end

    // Shift is resolved before the latch decision so a coincident latch sees the new bit.
    always_comb begin
        shreg_nx = shreg;
        cnt_nx   = bit_cnt;
        if (sclk_rise_p0) begin
            shreg_nx = (shreg << 1) | DATA_W'(sin_s);
            cnt_nx   = sat_inc_cnt(bit_cnt);
        end
    end

    // Stage p1: shift register, row commit and error accounting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg      <= '0;
            bit_cnt    <= '0;
            rows       <= '0;
            row_valid  <= '0;
            update     <= 1'b0;
            update_row <= '0;
            len_err    <= 1'b0;
            err_cnt    <= '0;
        end else begin
            update  <= 1'b0;
            len_err <= 1'b0;
            shreg   <= shreg_nx;
            if (latch_rise_p0) begin
                bit_cnt <= '0;
                if (cnt_nx == CNT_FULL) begin
                    rows[csel_s]      <= shreg_nx;
                    row_valid[csel_s] <= 1'b1;
                    update            <= 1'b1;
                    update_row        <= csel_s;
                end else begin
                    len_err <= 1'b1;
                    err_cnt <= sat_inc16(err_cnt);
                end
            end else begin
                bit_cnt <= cnt_nx;
            end
        end
    end

    assign row_data_o   = rows;
    assign row_valid_o  = row_valid;
    assign update_o     = update;
    assign update_row_o = update_row;
    assign blank_o      = blank_sync[SYNC_STAGES-1];
    assign len_err_o    = len_err;
    assign err_cnt_o    = err_cnt;

endmodule

// File: tb/tb_display_rx.sv
// Directed bench for display_rx: good, short, overrun and coincident frames, reset, blank, saturation.
module tb_display_rx;

    localparam int DATA_W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 latch_i, blank_i, sclk_i, sin_i;
    logic [2:0]           csel_i;
    logic [8*DATA_W-1:0]  row_data_o;
    logic [7:0]           row_valid_o;
    logic                 update_o, blank_o, len_err_o;
    logic [2:0]           update_row_o;
    logic [15:0]          err_cnt_o;

    int errors = 0;
    int checks = 0;
    int n_upd, n_err, first_upd;
    logic [DATA_W-1:0] saved_row;

    display_rx #(.DATA_W(DATA_W), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .latch_i(latch_i), .blank_i(blank_i), .csel_i(csel_i),
        .sclk_i(sclk_i), .sin_i(sin_i), .row_data_o(row_data_o), .row_valid_o(row_valid_o),
        .update_o(update_o), .update_row_o(update_row_o), .blank_o(blank_o),
        .len_err_o(len_err_o), .err_cnt_o(err_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] row(input int r);
        return row_data_o[r*DATA_W +: DATA_W];
    endfunction

    task automatic send_bit(input logic b);
        sin_i  = b;
        sclk_i = 1'b0;
        repeat (3) @(negedge clk);
        sclk_i = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic send_bits(input logic [63:0] w, input int n);
        for (int i = n - 1; i >= 0; i--) send_bit(w[i]);
    endtask

    // Raises latch (optionally together with sclk) and counts flag pulses in the following window.
    task automatic pulse_latch(input logic [2:0] c, input logic with_sclk);
        if (!with_sclk) begin
            csel_i = c;
            repeat (3) @(negedge clk);
        end
        latch_i = 1'b1;
        if (with_sclk) sclk_i = 1'b1;
        n_upd = 0; n_err = 0; first_upd = -1;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (update_o) begin
                n_upd++;
                if (first_upd < 0) first_upd = k;
            end
            if (len_err_o) n_err++;
        end
        latch_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; latch_i = 1'b0; blank_i = 1'b0; sclk_i = 1'b0; sin_i = 1'b0; csel_i = 3'd0;
        repeat (3) @(negedge clk);
        chk("rst_rows", {32'd0, row_data_o[63:0] | row_data_o[255:192]}, 64'd0);
        chk("rst_valid", row_valid_o, 8'h00);
        chk("rst_flags", {update_o, len_err_o, blank_o, update_row_o}, 6'd0);
        chk("rst_errcnt", err_cnt_o, 16'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Good row
        send_bits(64'hA5A5_0F0F, 32);
        pulse_latch(3'd3, 1'b0);
        chk("good_upd_cnt", n_upd, 1);
        chk("good_upd_lat", first_upd, 4);
        chk("good_err_cnt", n_err, 0);
        chk("good_row_idx", update_row_o, 3'd3);
        chk("good_row3", row(3), 32'hA5A5_0F0F);
        chk("good_valid", row_valid_o, 8'h08);
        chk("good_errcnt", err_cnt_o, 16'd0);

        // Short frame
        send_bits(64'h7FFF_FFFF, 31);
        pulse_latch(3'd0, 1'b0);
        chk("short_err", n_err, 1);
        chk("short_upd", n_upd, 0);
        chk("short_errcnt", err_cnt_o, 16'd1);
        chk("short_row0", row(0), 32'd0);
        chk("short_valid", row_valid_o, 8'h08);

        // Overrun then good frame to row 7
        send_bits(64'hFF_FFFF_FFFF, 40);
        pulse_latch(3'd7, 1'b0);
        chk("ovr_err", n_err, 1);
        chk("ovr_upd", n_upd, 0);
        chk("ovr_errcnt", err_cnt_o, 16'd2);
        chk("ovr_row7", row(7), 32'd0);
        send_bits(64'h1234_5678, 32);
        pulse_latch(3'd7, 1'b0);
        chk("row7_upd", n_upd, 1);
        chk("row7_val", row(7), 32'h1234_5678);
        chk("row7_valid", row_valid_o, 8'h88);

        // Coincident 32nd sclk rise and latch rise into row 2
        csel_i = 3'd2;
        send_bits(64'h6187_AD2D, 31);
        sin_i = 1'b1; sclk_i = 1'b0;
        repeat (3) @(negedge clk);
        pulse_latch(3'd2, 1'b1);
        chk("coin_upd", n_upd, 1);
        chk("coin_err", n_err, 0);
        chk("coin_row2", row(2), 32'hC30F_5A5B);
        chk("coin_idx", update_row_o, 3'd2);

        // Reset mid-frame, sclk held high across release
        send_bits(64'hFFFF, 16);
        rst = 1'b1;
        #1;
        chk("mrst_row2", row(2), 32'd0);
        chk("mrst_row7", row(7), 32'd0);
        chk("mrst_valid", row_valid_o, 8'h00);
        chk("mrst_errcnt", err_cnt_o, 16'd0);
        chk("mrst_idx", update_row_o, 3'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        send_bits(64'h0BAD_F00D, 32);
        pulse_latch(3'd2, 1'b0);
        chk("mrst_upd", n_upd, 1);
        chk("mrst_err", n_err, 0);
        chk("mrst_row2_new", row(2), 32'h0BAD_F00D);
        chk("mrst_errcnt2", err_cnt_o, 16'd0);
        chk("mrst_valid2", row_valid_o, 8'h04);

        // Blank follows after two cycles, rows untouched
        saved_row = row(2);
        blank_i = 1'b1;
        @(negedge clk);
        chk("blank_early", blank_o, 1'b0);
        @(negedge clk);
        chk("blank_on", blank_o, 1'b1);
        chk("blank_row", row(2), saved_row);
        blank_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("blank_off", blank_o, 1'b0);

        // Error counter saturation
        force dut.err_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.err_cnt;
        @(negedge clk);
        send_bits(64'h5, 4);
        pulse_latch(3'd1, 1'b0);
        chk("sat_err", n_err, 1);
        chk("sat_upd", n_upd, 0);
        chk("sat_errcnt", err_cnt_o, 16'hFFFF);
        chk("sat_row2", row(2), 32'h0BAD_F00D);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
